// File: rtl/logic_op_pipe_if.sv
// Bus bundle for logic_op_pipe: operand input handshake, combinational taps,
// pipelined result handshake and transfer counter.
interface logic_op_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_comb_assign;
    logic [WIDTH-1:0] out_comb_always;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_op;
    logic [CNT_W-1:0] xfer_count;

    // Stimulus / consumer side
    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, out_comb_assign, out_comb_always,
        input  out_valid, out_data, out_op, xfer_count
    );

    // Design side
    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, out_comb_assign, out_comb_always,
        output out_valid, out_data, out_op, xfer_count
    );
endinterface

// File: rtl/logic_op_pipe.sv
// Selectable bitwise logic op (AND/OR/XOR/NAND) with two combinational taps and an
// elastic valid/ready pipeline of STAGES registers plus a saturating transfer counter.
module logic_op_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          resetn,
    logic_op_pipe_if.slave bus
);
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0][1:0]       op_q, op_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [STAGES-1:0]            load_c;
    logic                         xfer_c;

    // Ternary chain in both taps so an X on op propagates identically through each
    assign bus.out_comb_assign = (bus.op == 2'b00) ? (bus.a & bus.b) :
                                 (bus.op == 2'b01) ? (bus.a | bus.b) :
                                 (bus.op == 2'b10) ? (bus.a ^ bus.b) :
                                                     ~(bus.a & bus.b);

    always_comb begin
        bus.out_comb_always = (bus.op == 2'b00) ? (bus.a & bus.b) :
                              (bus.op == 2'b01) ? (bus.a | bus.b) :
                              (bus.op == 2'b10) ? (bus.a ^ bus.b) :
                                                  ~(bus.a & bus.b);
    end

    // Ready chain: a stage loads when empty or when its successor loads
    always_comb begin
        logic ld;
        load_c = '0;
        ld     = bus.out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ld        = !vld_q[k] || ld;
            load_c[k] = ld;
        end
    end

    assign bus.in_ready = load_c[0];
    assign xfer_c       = vld_q[LAST] && bus.out_ready;

    // Stage advance and counter next-state
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        op_d   = op_q;
        cnt_d  = cnt_q;

        if (load_c[0]) begin
            vld_d[0]  = bus.in_valid;
            data_d[0] = bus.out_comb_assign;
            op_d[0]   = bus.op;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (load_c[k]) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
                op_d[k]   = op_q[k-1];
            end
        end

        if (xfer_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q  <= '0;
            data_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.out_valid  = vld_q[LAST];
    assign bus.out_data   = data_q[LAST];
    assign bus.out_op     = op_q[LAST];
    assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe (WIDTH=8, STAGES=2, CNT_W=4).
module tb_logic_op_pipe;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    logic_op_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 8'h3C;
        bus.b         = 8'hFF;
        bus.op        = 2'b00;
        repeat (2) step();
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
        n_checks++;
        if (bus.out_op !== 2'b00) begin n_fail++; $display("FAIL reset_out_op got %b want 00", bus.out_op); end
        n_checks++;
        if (bus.xfer_count !== 4'd0) begin n_fail++; $display("FAIL reset_xfer_count got %0d want 0", bus.xfer_count); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        // Accepts offered during reset must not surface
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ignored_accept cyc %0d got %b want 0", c, bus.out_valid); end
        end
    endtask

    task automatic test_comb_truth();
        logic [7:0] vals [4];
        logic [7:0] exp;
        logic [7:0] spot_exp [4];
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h0F; vals[3] = 8'hA5;
        spot_exp[0] = 8'h05; spot_exp[1] = 8'hAF; spot_exp[2] = 8'hAA; spot_exp[3] = 8'hFA;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int o = 0; o < 4; o++) begin
                    bus.a  = vals[i];
                    bus.b  = vals[j];
                    bus.op = 2'(o);
                    case (o)
                        0:       exp = vals[i] & vals[j];
                        1:       exp = vals[i] | vals[j];
                        2:       exp = vals[i] ^ vals[j];
                        default: exp = ~(vals[i] & vals[j]);
                    endcase
                    @(negedge clk);
                    n_checks++;
                    if (bus.out_comb_assign !== exp) begin n_fail++; $display("FAIL comb_assign a=%h b=%h op=%0d got %h want %h", vals[i], vals[j], o, bus.out_comb_assign, exp); end
                    n_checks++;
                    if (bus.out_comb_always !== bus.out_comb_assign) begin n_fail++; $display("FAIL comb_equal_neg got %h want %h", bus.out_comb_always, bus.out_comb_assign); end
                    @(posedge clk);
                    n_checks++;
                    if (bus.out_comb_always !== bus.out_comb_assign) begin n_fail++; $display("FAIL comb_equal_pos got %h want %h", bus.out_comb_always, bus.out_comb_assign); end
                    if (i == 3 && j == 2) begin
                        n_checks++;
                        if (bus.out_comb_always !== spot_exp[o]) begin n_fail++; $display("FAIL comb_a5_0f op=%0d got %h want %h", o, bus.out_comb_always, spot_exp[o]); end
                    end
                end
            end
        end
        #1;
        bus.a  = 8'hA5;
        bus.b  = 8'h0F;
        bus.op = 2'bxx;
        #1;
        n_checks++;
        if (bus.out_comb_always !== bus.out_comb_assign) begin n_fail++; $display("FAIL comb_x_op got %b want %b", bus.out_comb_always, bus.out_comb_assign); end
        bus.op = 2'b00;
    endtask

    task automatic test_latency_throughput();
        do_reset(1);
        bus.out_ready = 1'b1;
        bus.b         = 8'hFF;
        bus.op        = 2'b00;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 10);
            bus.a        = 8'(c);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready cyc %0d got %b want 1", c, bus.in_ready); end
            n_checks++;
            if (bus.out_valid !== (c >= 2)) begin n_fail++; $display("FAIL lat_out_valid cyc %0d got %b want %b", c, bus.out_valid, (c >= 2)); end
            if (c >= 2) begin
                n_checks++;
                if (bus.out_data !== 8'(c - 2)) begin n_fail++; $display("FAIL lat_out_data cyc %0d got %h want %h", c, bus.out_data, 8'(c - 2)); end
            end
            step();
        end
        #1;
        n_checks++;
        if (bus.xfer_count !== 4'd10) begin n_fail++; $display("FAIL lat_xfer_count got %0d want 10", bus.xfer_count); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.b         = 8'h00;
        bus.op        = 2'b10;
        for (int c = 0; c < 6; c++) begin
            bus.a = 8'h20 + 8'(c);
            #1;
            n_checks++;
            if (bus.in_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want %b", c, bus.in_ready, (c < 2)); end
            if (c >= 2) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20 || bus.out_op !== 2'b10) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc %0d got v=%b d=%h op=%b want v=1 d=20 op=10", c, bus.out_valid, bus.out_data, bus.out_op);
                end
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20) begin n_fail++; $display("FAIL bp_drain0 got v=%b d=%h want v=1 d=20", bus.out_valid, bus.out_data); end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21) begin n_fail++; $display("FAIL bp_drain1 got v=%b d=%h want v=1 d=21", bus.out_valid, bus.out_data); end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_empty got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.xfer_count !== 4'd2) begin n_fail++; $display("FAIL bp_xfer_count got %0d want 2", bus.xfer_count); end
    endtask

    task automatic test_back_to_back_full();
        do_reset(1);
        bus.b  = 8'h00;
        bus.op = 2'b01;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bus.a = 8'h40 + 8'(c);
            step();
        end
        bus.out_ready = 1'b1;
        for (int c = 2; c < 7; c++) begin
            bus.a = 8'h40 + 8'(c);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready cyc %0d got %b want 1", c, bus.in_ready); end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h40 + 8'(c - 2)) begin
                n_fail++;
                $display("FAIL full_out cyc %0d got v=%b d=%h want v=1 d=%h", c, bus.out_valid, bus.out_data, 8'h40 + 8'(c - 2));
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_still_full got %b want 0", bus.in_ready); end
        n_checks++;
        if (bus.xfer_count !== 4'd5) begin n_fail++; $display("FAIL full_xfer_count got %0d want 5", bus.xfer_count); end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h45) begin n_fail++; $display("FAIL full_tail0 got v=%b d=%h want v=1 d=45", bus.out_valid, bus.out_data); end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h46) begin n_fail++; $display("FAIL full_tail1 got v=%b d=%h want v=1 d=46", bus.out_valid, bus.out_data); end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_tail_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_saturation_reset();
        int exp_cnt;
        do_reset(1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.b         = 8'hFF;
        bus.op        = 2'b00;
        for (int c = 0; c < 22; c++) begin
            bus.a = 8'(c);
            #1;
            exp_cnt = (c < 2) ? 0 : ((c - 2) > 15 ? 15 : (c - 2));
            n_checks++;
            if (bus.xfer_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL sat_count cyc %0d got %0d want %0d", c, bus.xfer_count, exp_cnt); end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.xfer_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", bus.xfer_count); end
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h14) begin
            n_fail++;
            $display("FAIL sat_inflight got rdy=%b v=%b d=%h want rdy=0 v=1 d=14", bus.in_ready, bus.out_valid, bus.out_data);
        end
        resetn        = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h77;
        step();
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.xfer_count !== 4'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_post_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", bus.out_valid, bus.xfer_count, bus.in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.xfer_count !== 4'd0) begin
                n_fail++;
                $display("FAIL sat_discarded cyc %0d got v=%b cnt=%0d want v=0 cnt=0", c, bus.out_valid, bus.xfer_count);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_comb_truth();
        test_latency_throughput();
        test_backpressure();
        test_back_to_back_full();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised successor to the single-bit two-output AND primitive.
- Computes a selectable bitwise logic operation on two WIDTH-bit operands.
- Exposes the result two ways: combinational, through an assign path and an always-block path that must be identical, and through an elastic valid/ready pipeline of STAGES registers.
- Sits between stimulus sources and downstream consumers; a saturating transfer counter supports bench bookkeeping.

Parameters:
- WIDTH, 8: operand/result width in bits (>=1).
- STAGES, 2: pipeline register stages, legal 1..4.
- CNT_W, 16: width of the transfer counter (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_valid  input  1  a/b/op valid this cycle.
- in_ready  output  1  block accepts a/b/op this cycle.
- out_comb_assign  output  WIDTH  f(a,b,op), continuous-assign form, no registers.
- out_comb_always  output  WIDTH  same function, combinational always-block form.
- out_valid  output  1  out_data/out_op valid.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  pipelined result.
- out_op  output  2  op that produced out_data.
- xfer_count  output  CNT_W  number of completed output transfers, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (resetn).
- Combinational outputs:
  - out_comb_assign and out_comb_always equal f(a,b,op) in the same time step, independent of clk, resetn and the handshake.
  - The two must never differ, including under X on op: both propagate X identically.
- Pipeline structure: STAGES stage registers s[0..STAGES-1]. Each stage holds a valid bit, a WIDTH-bit result and a 2-bit op. Stage 0 captures f(a,b,op) on accept.
- Accept and transfer rules:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid = s[STAGES-1].valid; out_data/out_op come from the same stage.
- Ready chain:
  - Stage k may load when it is empty or when stage k+1 loads (last stage: when out_ready).
  - in_ready = load condition of stage 0.
  - in_ready is combinational from out_ready through the chain; there is no combinational path from in_valid to in_ready.
- Timing:
  - Latency: a value accepted at edge N appears on out_valid/out_data after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1, when no stall occurs.
  - Throughput: one transfer per cycle with out_ready held high.
- Stall:
  - While out_valid && !out_ready, out_data and out_op hold stable.
  - No stage bubble is destroyed or duplicated; upstream stages keep filling until the pipeline is full (STAGES entries), then in_ready=0.
- Simultaneous events:
  - With a full pipeline, out_ready=1 and in_valid=1: one transfer and one accept occur on the same edge; occupancy is unchanged.
  - A stage that is empty never blocks.
- Transfer counter:
  - xfer_count increments by 1 on each output transfer.
  - It saturates at 2^CNT_W-1 and holds there; it never wraps.
- Reset:
  - resetn=0 at an edge clears all stage valid bits, results and ops to 0, and clears xfer_count to 0.
  - Reset values: out_valid=0, out_data=0, out_op=0, xfer_count=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards in-flight data; no output transfer is counted on the reset edge.
  - While resetn=0, in_ready may be 1 but accepts are ignored.
- Widths: results are exactly WIDTH bits, with no extension. NAND is the bitwise inverse of AND over all WIDTH bits.

Test Plan:
- Reset:
  - Stimulus: hold resetn=0 for 2 cycles, then release.
  - Response: out_valid=0, out_data=0, out_op=0, xfer_count=0, in_ready=1.
- Combinational truth table (WIDTH=8):
  - Stimulus: sweep a,b over {00,FF,0F,A5} with all four ops.
  - Response: for a=A5, b=0F: AND=05, OR=AF, XOR=AA, NAND=FA. out_comb_assign === out_comb_always on every sample on both clock edges.
- Latency and throughput (STAGES=2):
  - Stimulus: out_ready=1; stream 10 back-to-back transactions (a=count, b=FF, op=00).
  - Response: first out_valid one cycle after the first accept; out_data sequence 00..09 with no gaps; xfer_count=10.
- Backpressure:
  - Stimulus: out_ready=0 with in_valid=1 continuously.
  - Response: in_ready drops after exactly STAGES accepts; out_data holds stable. Raising out_ready drains the entries in order with no loss or duplication.
- Full pipeline with simultaneous accept and transfer:
  - Stimulus: full pipeline, in_valid=1 and out_ready=1 for 5 cycles.
  - Response: 5 accepts and 5 transfers; occupancy stays at STAGES.
- Saturation and mid-run reset:
  - Stimulus: CNT_W=4; 20 transfers, then resetn=0 for 1 cycle while 2 entries are in flight.
  - Response: xfer_count stops at 15. After reset, out_valid=0 and xfer_count=0; the discarded entries never appear.
